reg_bank: RTL and testbench
===========================

# reg_bank

Register bank for the FP-F2 datapath: 32 general registers of 32 bits, two combinational read ports and one synchronous write port. The write-data port is driven directly by the write-back select multiplexer, whose 32-bit result is written here. After reset a built-in sequencer clears the array one register per cycle, so the storage can map to memory without a per-entry reset. Register 0 reads as zero at all times.

## Interface
- DW, 32, data width of each register and of wd/rd1/rd2
- AW, 5, address width; register count is 2**AW

- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- we  input  1  write enable, sampled at the rising edge
- wa  input  AW  write address
- wd  input  DW  write data (write-back multiplexer output)
- ra1  input  AW  read address, port 1
- ra2  input  AW  read address, port 2
- rd1  output  DW  read data, port 1 (combinational)
- rd2  output  DW  read data, port 2 (combinational)
- busy  output  1  high while the clear sequence runs; the bank is unusable while it is high

## Operation
- Storage: array mem[1..2**AW-1] of DW bits, no reset on the array itself; register 0 is not stored.
- State machine, two states: INIT (busy=1), RUN (busy=0). Clear counter cnt, AW bits.
- rst=1 at an edge: state<=INIT, cnt<=1, no array write. rst has priority over everything, in every state.
- INIT, rst=0 at an edge: mem[cnt]<=0, cnt<=cnt+1; if cnt==2**AW-1, state<=RUN. The counter must not wrap to 0 (it stops on the transition).
- INIT: we is ignored; writes are dropped silently, not queued.
- RUN, rst=0, we=1, wa!=0 at an edge: mem[wa]<=wd. we=1 with wa==0: no effect.
- Read, each port independently, priority order:
  - busy=1 -> rdN=0
  - raN==0 -> rdN=0
  - we=1 and wa==raN (RUN) -> rdN=wd (write-through bypass, same cycle)
  - otherwise rdN=mem[raN]
- Both ports may address the same register, including the one being written; both return identical data.
- rst asserted mid-INIT restarts the clear at cnt=1. rst asserted in RUN re-enters INIT and clears all contents again.

## Timing
- Power-up state before the first reset edge is undefined; the bench must apply rst for at least one edge.
- After the edge with rst=1: busy=1, rd1=rd2=0 from that edge onward.
- Clear takes 2**AW-1 edges (31 by default) with rst=0; busy falls right after the edge that clears the last register.
- First accepted write: the first edge with busy=0 beforehand (edge 32 after the reset edge for AW=5).
- Write latency: data at edge n is visible through mem from after edge n; through the bypass it is already visible on rd1/rd2 during the cycle before edge n.
- Reads are purely combinational from ra1/ra2/we/wa/wd/state; there is no read latency.

## Test plan
- Reset held one edge, then released -> busy=1 for exactly 31 edges, rd1=rd2=0 throughout; after busy falls, reading every address 0..31 returns 0x00000000.
- RUN: we=1, wa=5, wd=0xDEADBEEF for one edge, then ra1=5 -> rd1=0xDEADBEEF; write wa=5 with 0x12345678 -> rd1 changes to the new value.
- Bypass: ra1=ra2=9, we=1, wa=9, wd=0xA5A5A5A5 in the same cycle -> rd1=rd2=0xA5A5A5A5 before the edge; still 0xA5A5A5A5 after the edge with we=0.
- Register 0: we=1, wa=0, wd=0xFFFFFFFF -> ra1=0 gives rd1=0, both during the write cycle and after it.
- Write during INIT: 3 edges after reset, write wa=7 with 0x11111111 -> dropped; after busy falls, ra2=7 gives rd2=0.
- Reset mid-clear: reapply rst at edge 10 of INIT -> busy stays high for 31 further edges; a register written before the first reset (for example x31=0x0BADF00D) reads 0 afterwards.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: 2**AW x DW register bank, two combinational read ports, one
// synchronous write port. After reset a sequencer clears registers
// 1..2**AW-1, one per cycle, so the array itself needs no per-entry reset.
// Register 0 is not stored and always reads as zero.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset (restarts the clear sequence)
//   we/wa/wd - write enable / address / data (ignored while busy)
//   ra1/rd1  - read port 1 address / data (combinational)
//   ra2/rd2  - read port 2 address / data (combinational)
//   busy     - high while the clear sequence runs
module reg_bank #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  // Register 0 has no storage.
  logic [DW-1:0] mem [1:(2**AW)-1];

  // Next-state and array write-port selection. The array port is shared
  // between the clear sequencer (INIT) and the user write (RUN).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          mem_we = 1'b1;
          mem_wa = cnt_q;
          mem_wd = '0;
          // Counter holds at the last address instead of wrapping to 0.
          if (cnt_q == '1) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        ST_RUN: begin
          if (we && (wa != '0)) begin
            mem_we = 1'b1;
            mem_wa = wa;
            mem_wd = wd;
          end
        end
        default: begin
          state_d = ST_INIT;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= AW'(1);
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read ports: busy masks everything, then register 0, then the
  // same-cycle write-through bypass, then the stored value.
  always_comb begin
    rd1 = '0;
    if (busy_q) begin
      rd1 = '0;
    end else if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = mem[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (busy_q) begin
      rd2 = '0;
    end else if (ra2 == '0) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = mem[ra2];
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank: expected read results are pushed to a scoreboard
// queue as stimulus is applied and popped when the outputs are sampled.
module tb_reg_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          busy;

  typedef struct {
    logic          busy;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [0:(2**AW)-1];
  int            errors = 0;
  int            checks = 0;

  reg_bank #(.DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model of a write at the next edge while the bank is in RUN.
  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a != '0) model[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    step();
    rst = 1'b0;
    model_clear();
    n = 0;
    // While clearing, drive writes to varying addresses; all must be dropped.
    while (busy === 1'b1 && n < 100) begin
      ra1 = AW'(n); ra2 = AW'(31 - (n % 32)); we = 1'b1; wa = AW'(n); wd = $urandom() | 32'h1;
      sb.push_back('{busy: 1'b1, rd1: '0, rd2: '0});
      #1;
      e = sb.pop_front();
      checks++;
      if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
        errors++;
        $display("FAIL reset_busy_read n=%0d got busy=%b rd1=%h rd2=%h want busy=%b rd1=%h rd2=%h",
                 n, busy, rd1, rd2, e.busy, e.rd1, e.rd2);
      end
      step();
      n++;
    end
    we = 1'b0;
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL reset_busy_len got %0d edges want 31", n);
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = AW'(i); ra2 = AW'(31 - i);
      sb.push_back('{busy: 1'b0, rd1: model[i], rd2: model[31 - i]});
      #1;
      e = sb.pop_front();
      checks++;
      if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
        errors++;
        $display("FAIL reset_cleared addr=%0d got busy=%b rd1=%h rd2=%h want busy=%b rd1=%h rd2=%h",
                 i, busy, rd1, rd2, e.busy, e.rd1, e.rd2);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [DW-1:0] vals [2];
    vals[0] = 32'hDEADBEEF;
    vals[1] = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      we = 1'b1; wa = 5'd5; wd = vals[k]; ra1 = 5'd3; ra2 = 5'd4;
      step();
      model_write(5'd5, vals[k]);
      we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
      sb.push_back('{busy: 1'b0, rd1: model[5], rd2: model[5]});
      #1;
      e = sb.pop_front();
      checks++;
      if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
        errors++;
        $display("FAIL write_read k=%0d got rd1=%h rd2=%h want rd1=%h rd2=%h",
                 k, rd1, rd2, e.rd1, e.rd2);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    ra1 = 5'd9; ra2 = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
    sb.push_back('{busy: 1'b0, rd1: 32'hA5A5A5A5, rd2: 32'hA5A5A5A5});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL bypass_same_cycle got rd1=%h rd2=%h want rd1=%h rd2=%h", rd1, rd2, e.rd1, e.rd2);
    end
    step();
    model_write(5'd9, 32'hA5A5A5A5);
    we = 1'b0;
    sb.push_back('{busy: 1'b0, rd1: model[9], rd2: model[9]});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL bypass_after_edge got rd1=%h rd2=%h want rd1=%h rd2=%h", rd1, rd2, e.rd1, e.rd2);
    end
  endtask

  task automatic test_reg0();
    exp_t e;
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    sb.push_back('{busy: 1'b0, rd1: '0, rd2: '0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL reg0_during_write got rd1=%h rd2=%h want rd1=%h rd2=%h", rd1, rd2, e.rd1, e.rd2);
    end
    step();
    we = 1'b0;
    sb.push_back('{busy: 1'b0, rd1: '0, rd2: '0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL reg0_after_write got rd1=%h rd2=%h want rd1=%h rd2=%h", rd1, rd2, e.rd1, e.rd2);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 1; i <= 8; i++) begin
      we = 1'b1; wa = AW'(i + 10); wd = 32'h01010101 * i;
      ra1 = AW'(i + 10); ra2 = AW'(i + 9);
      // Port 1 sees the bypass, port 2 the register written one edge earlier.
      sb.push_back('{busy: 1'b0, rd1: 32'h01010101 * i, rd2: model[i + 9]});
      #1;
      e = sb.pop_front();
      checks++;
      if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
        errors++;
        $display("FAIL back_to_back i=%0d got rd1=%h rd2=%h want rd1=%h rd2=%h",
                 i, rd1, rd2, e.rd1, e.rd2);
      end
      step();
      model_write(AW'(i + 10), 32'h01010101 * i);
    end
    we = 1'b0;
  endtask

  task automatic test_write_during_init();
    exp_t e;
    int   n;
    rst = 1'b1; we = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
    n = 0;
    // Attempts at edge 4 (before x7 is cleared) and edge 20 (after).
    while (busy === 1'b1 && n < 100) begin
      if (n == 3 || n == 19) begin
        we = 1'b1; wa = 5'd7; wd = 32'h11111111;
      end else begin
        we = 1'b0;
      end
      ra1 = 5'd7; ra2 = 5'd7;
      sb.push_back('{busy: 1'b1, rd1: '0, rd2: '0});
      #1;
      e = sb.pop_front();
      checks++;
      if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
        errors++;
        $display("FAIL init_write_busy n=%0d got busy=%b rd1=%h rd2=%h want busy=%b rd1=%h rd2=%h",
                 n, busy, rd1, rd2, e.busy, e.rd1, e.rd2);
      end
      step();
      n++;
    end
    we = 1'b0;
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL init_write_len got %0d edges want 31", n);
    end
    ra2 = 5'd7; ra1 = 5'd5;
    sb.push_back('{busy: 1'b0, rd1: model[5], rd2: model[7]});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL init_write_dropped got busy=%b rd1=%h rd2=%h want busy=%b rd1=%h rd2=%h",
               busy, rd1, rd2, e.busy, e.rd1, e.rd2);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    int   n;
    we = 1'b1; wa = 5'd31; wd = 32'h0BADF00D;
    step();
    model_write(5'd31, 32'h0BADF00D);
    we = 1'b0; ra1 = 5'd31; ra2 = 5'd31;
    sb.push_back('{busy: 1'b0, rd1: model[31], rd2: model[31]});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL mid_clear_prewrite got rd1=%h rd2=%h want rd1=%h rd2=%h", rd1, rd2, e.rd1, e.rd2);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL mid_clear_len got %0d edges want 31", n);
    end
    ra1 = 5'd31; ra2 = 5'd9;
    sb.push_back('{busy: 1'b0, rd1: model[31], rd2: model[9]});
    #1;
    e = sb.pop_front();
    checks++;
    if ({busy, rd1, rd2} !== {e.busy, e.rd1, e.rd2}) begin
      errors++;
      $display("FAIL mid_clear_contents got busy=%b rd1=%h rd2=%h want busy=%b rd1=%h rd2=%h",
               busy, rd1, rd2, e.busy, e.rd1, e.rd2);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_reg0();
    test_back_to_back();
    test_write_during_init();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
